// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: program loading, control from the CPU, and the instruction stream back to it.
// The CPU/loader side drives through master; inst_fetch is the slave.
interface inst_fetch_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   Inst;
  logic          inst_valid;
  logic [31:0]   pc;
  logic          halted;

  modport master (
    output start, prog_we, prog_addr, prog_data, stall, redirect, redirect_pc,
    input  Inst, inst_valid, pc, halted
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, stall, redirect, redirect_pc,
    output Inst, inst_valid, pc, halted
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit with its own program store.
// It loads while idle, streams words to the CPU in RUN, and stops on an all-ones opcode.
module inst_fetch #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;
  logic        r_halted;
  logic [31:0] r_mem [DEPTH];

  logic [31:0] w_word;
  logic        w_halt_op;
  logic        w_prog_ok;
  logic        w_unused_bits;

  assign w_word        = r_mem[r_pc[AW+1:2]];
  assign w_halt_op     = (w_word[31:26] == 6'b111111);
  assign w_prog_ok     = (r_state != RUN);
  assign w_unused_bits = &{1'b0, bus.redirect_pc[1:0]};

  // Program store has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_prog_ok && bus.prog_we)
      r_mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LOAD;
      r_pc     <= RESET_PC;
      r_inst   <= 32'h0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        LOAD, HALT: begin
          if (bus.start) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
          end
        end
        RUN: begin
          // Redirect flushes even when stalled; a halt word in its shadow is dropped.
          if (bus.redirect) begin
            r_pc    <= {bus.redirect_pc[31:2], 2'b00};
            r_inst  <= 32'h0;
            r_valid <= 1'b0;
          end else if (!bus.stall) begin
            if (w_halt_op) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
              r_inst   <= 32'h0;
              r_valid  <= 1'b0;
            end else begin
              r_inst  <= w_word;
              r_valid <= 1'b1;
              r_pc    <= r_pc + 32'd4;
            end
          end
        end
        default: begin
          r_state  <= LOAD;
          r_inst   <= 32'h0;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Inst       = r_inst;
  assign bus.inst_valid = r_valid;
  assign bus.pc         = r_pc;
  assign bus.halted     = r_halted;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a driver queues hand-computed expectations,
// a monitor pops them at each falling edge (or on demand for async reset).
module tb_inst_fetch;
  typedef struct {
    logic [31:0] inst;
    logic        v;
    logic [31:0] pc;
    logic        h;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t  q[$];
  string nq[$];
  event  ev_now;
  int    total;
  int    passed;

  inst_fetch_if #(.DEPTH(64)) bus();

  inst_fetch #(.DEPTH(64), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [31:0] ei, input logic ev, input logic [31:0] ep,
                      input logic eh, input string nm);
    exp_t e;
    e.inst = ei; e.v = ev; e.pc = ep; e.h = eh;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  // One clock: drive inputs away from the edge, then queue what must appear after it.
  task automatic step(input logic st, input logic we, input logic [5:0] ad, input logic [31:0] dt,
                      input logic sl, input logic rd, input logic [31:0] rp,
                      input logic [31:0] ei, input logic ev, input logic [31:0] ep,
                      input logic eh, input string nm);
    @(negedge clk);
    #1;
    bus.start = st; bus.prog_we = we; bus.prog_addr = ad; bus.prog_data = dt;
    bus.stall = sl; bus.redirect = rd; bus.redirect_pc = rp;
    @(posedge clk);
    push(ei, ev, ep, eh, nm);
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk or ev_now);
      if (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        total++;
        if (bus.Inst !== e.inst || bus.inst_valid !== e.v || bus.pc !== e.pc || bus.halted !== e.h)
          $display("FAIL %s: got Inst=%h valid=%b pc=%h halted=%b, expected Inst=%h valid=%b pc=%h halted=%b",
                   nm, bus.Inst, bus.inst_valid, bus.pc, bus.halted, e.inst, e.v, e.pc, e.h);
        else
          passed++;
      end
    end
  end

  initial begin : driver
    total = 0; passed = 0;
    bus.start = 0; bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    rst_n = 1'b0;
    #1;
    push(32'h0, 0, 32'h0, 0, "reset_state");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Program load; mem[0] is written on the same edge as start.
    step(0, 1, 6'd1,  32'h2002_0001, 0, 0, 0, 32'h0, 0, 32'h0, 0, "load1");
    step(0, 1, 6'd2,  32'h0021_1020, 0, 0, 0, 32'h0, 0, 32'h0, 0, "load2");
    step(0, 1, 6'd3,  32'hFC00_0000, 0, 0, 0, 32'h0, 0, 32'h0, 0, "load3");
    step(0, 1, 6'd4,  32'hAAAA_0004, 0, 0, 0, 32'h0, 0, 32'h0, 0, "load4");
    step(0, 1, 6'd63, 32'hCCCC_003F, 0, 0, 0, 32'h0, 0, 32'h0, 0, "load63");
    step(1, 1, 6'd0,  32'h2001_0001, 0, 0, 0, 32'h0, 0, 32'h0, 0, "start_with_write");

    step(0, 0, 0, 0, 0, 0, 0, 32'h2001_0001, 1, 32'd4,  0, "fetch0");
    step(0, 0, 0, 0, 0, 0, 0, 32'h2002_0001, 1, 32'd8,  0, "fetch1");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 1, 0, 0, 32'h2002_0001, 1, 32'd8, 0, "stall_hold");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0021_1020, 1, 32'd12, 0, "fetch2");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'd12, 1, "halt_enter");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'd12, 1, "halt_hold");
    step(1, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'd0,  0, "restart");

    // Write attempt while running must be ignored (would plant a halt word at mem[1]).
    step(0, 1, 6'd1, 32'hFFFF_FFFF, 0, 0, 0, 32'h2001_0001, 1, 32'd4, 0, "fetch0_run_we");
    step(0, 0, 0, 0, 1, 1, 32'h0000_0013, 32'h0, 0, 32'h10, 0, "redirect_stall");
    step(0, 0, 0, 0, 0, 0, 0, 32'hAAAA_0004, 1, 32'h14, 0, "fetch_mem4");
    step(0, 0, 0, 0, 0, 1, 32'h0000_00FC, 32'h0, 0, 32'hFC, 0, "redirect_fc");
    step(0, 0, 0, 0, 0, 0, 0, 32'hCCCC_003F, 1, 32'h100, 0, "fetch_mem63");
    step(0, 0, 0, 0, 0, 0, 0, 32'h2001_0001, 1, 32'h104, 0, "wrap_mem0");
    step(0, 0, 0, 0, 0, 0, 0, 32'h2002_0001, 1, 32'h108, 0, "mem1_unchanged");
    step(0, 0, 0, 0, 0, 1, 32'h0000_000C, 32'h0, 0, 32'hC, 0, "redirect_to_halt");
    step(0, 0, 0, 0, 0, 1, 32'h0,         32'h0, 0, 32'h0, 0, "redirect_over_halt");
    step(0, 0, 0, 0, 0, 0, 0, 32'h2001_0001, 1, 32'd4, 0, "fetch_after_redir");

    // Asynchronous reset between edges, checked before the next clock edge.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    push(32'h0, 0, 32'h0, 0, "async_reset");
    -> ev_now;
    @(negedge clk);
    #1 rst_n = 1'b1;

    step(1, 0, 0, 0, 0, 0, 0, 32'h0,         0, 32'd0,  0, "start_after_reset");
    step(0, 0, 0, 0, 0, 0, 0, 32'h2001_0001, 1, 32'd4,  0, "replay0");
    step(0, 0, 0, 0, 0, 0, 0, 32'h2002_0001, 1, 32'd8,  0, "replay1");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0021_1020, 1, 32'd12, 0, "replay2");

    @(negedge clk);
    bus.start = 0; bus.prog_we = 0; bus.stall = 0; bus.redirect = 0;
    @(negedge clk);
    total++;
    if (q.size() != 0)
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
